// File: rtl/awgn_pkg.sv
// Shared constants, state encoding and seed helper for the AWGN URNG front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package awgn_pkg;

    localparam int          URNG_W        = 32;
    localparam logic [31:0] SEED_MIN      = 32'd16;
    localparam logic [31:0] SEED_DEFAULT  = 32'hACE1F00D;
    localparam logic [31:0] SEED_XOR_MASK = 32'h9E3779B9;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_WARM = 2'd2;
    localparam state_t ST_RUN  = 2'd3;

    // A Tausworthe component degenerates when its seed has no bits above the
    // component's shift mask; the widest mask covers bits [3:0].
    function automatic logic weak_seed(input logic [URNG_W-1:0] s);
        return (s < SEED_MIN);
    endfunction

endpackage

// File: rtl/urng_out_reg.sv
// Output register for the (u0,u1) pair; also produces the generator advance enable.
// Latency: 1 cycle from an enabled generator step to u_valid.
// Backpressure: while u_valid & !u_ready the pair holds and adv stays low (generators frozen).
//
// Ports: clk/reset; run (sequencer in RUN), flush (start/stop this cycle, drops any pair);
//        y0/y1 generator outputs; u_valid/u_ready/u0/u1 downstream handshake; adv advance enable.
module urng_out_reg
    import awgn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic [URNG_W-1:0] y0,
    input  logic [URNG_W-1:0] y1,
    input  logic              u_ready,
    output logic              u_valid,
    output logic [URNG_W-1:0] u0,
    output logic [URNG_W-1:0] u1,
    output logic              adv
);

    // The register can take a new pair when empty or when the current one
    // leaves this cycle; the generators step exactly when a pair is captured,
    // so no sample is skipped or repeated.
    assign adv = run & ~flush & (~u_valid | u_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u_valid <= 1'b0;
            u0      <= '0;
            u1      <= '0;
        end else if (flush) begin
            // u0/u1 keep their last value; only the valid flag is dropped.
            u_valid <= 1'b0;
        end else if (adv) begin
            u_valid <= 1'b1;
            u0      <= y0;
            u1      <= y1;
        end
    end

endmodule

// File: rtl/urng_seq_ctrl.sv
// Sequencer for two Tausworthe URNGs: seed load, warm-up discard, then (u0,u1) streaming.
// Latency: start -> LOAD_CYCLES load + WARMUP_CYCLES warm-up + 1 run cycle -> first u_valid.
// Backpressure: u_valid/u_ready; generators only advance when the output register takes a pair.
//
// Ports: clk/reset; start/stop pulses; seed_in; busy/warm_done status; urng_rst, urng_seed0/1,
//        urng_en, urng_y0/1 to the generators; u_valid/u_ready/u0/u1 pair stream; sample_cnt.
module urng_seq_ctrl #(
    parameter int          WARMUP_CYCLES = 64,
    parameter int          LOAD_CYCLES   = 2,
    parameter logic [31:0] SEED_XOR_MASK = awgn_pkg::SEED_XOR_MASK,
    parameter logic [31:0] SEED_DEFAULT  = awgn_pkg::SEED_DEFAULT,
    parameter int          CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [awgn_pkg::URNG_W-1:0] seed_in,
    output logic                        busy,
    output logic                        warm_done,
    output logic                        urng_rst,
    output logic [awgn_pkg::URNG_W-1:0] urng_seed0,
    output logic [awgn_pkg::URNG_W-1:0] urng_seed1,
    output logic                        urng_en,
    input  logic [awgn_pkg::URNG_W-1:0] urng_y0,
    input  logic [awgn_pkg::URNG_W-1:0] urng_y1,
    output logic                        u_valid,
    input  logic                        u_ready,
    output logic [awgn_pkg::URNG_W-1:0] u0,
    output logic [awgn_pkg::URNG_W-1:0] u1,
    output logic [CNT_W-1:0]            sample_cnt
);

    import awgn_pkg::*;

    // One counter serves both timed phases, so it is sized for the longer one.
    localparam int PH_MAX = (LOAD_CYCLES > WARMUP_CYCLES) ? LOAD_CYCLES : WARMUP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] LOAD_LAST = PH_W'(LOAD_CYCLES - 1);
    localparam logic [PH_W-1:0] WARM_LAST = PH_W'(WARMUP_CYCLES - 1);

    state_t            state;
    logic [PH_W-1:0]   phase;
    logic [URNG_W-1:0] seed;
    logic              flush;
    logic              adv;

    // Any start, or a stop outside IDLE, abandons the pair in flight.
    assign flush = start | (stop & (state != ST_IDLE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            phase <= '0;
            seed  <= SEED_DEFAULT;
        end else if (start) begin
            state <= ST_LOAD;
            phase <= '0;
            seed  <= weak_seed(seed_in) ? SEED_DEFAULT : seed_in;
        end else if (stop) begin
            state <= ST_IDLE;
            phase <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (phase == LOAD_LAST) begin
                        state <= ST_WARM;
                        phase <= '0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_WARM: begin
                    if (phase == WARM_LAST) begin
                        state <= ST_RUN;
                        phase <= '0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (start) begin
            sample_cnt <= '0;
        end else if (u_valid && u_ready && (sample_cnt != {CNT_W{1'b1}})) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    urng_out_reg u_out (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ST_RUN),
        .flush   (flush),
        .y0      (urng_y0),
        .y1      (urng_y1),
        .u_ready (u_ready),
        .u_valid (u_valid),
        .u0      (u0),
        .u1      (u1),
        .adv     (adv)
    );

    // Generators are held in seed-load whenever the sequencer is not stepping
    // them, so IDLE always leaves them at a known state.
    assign urng_rst   = (state == ST_IDLE) || (state == ST_LOAD);
    assign urng_en    = (state == ST_WARM) || adv;
    assign busy       = (state != ST_IDLE);
    assign warm_done  = (state == ST_RUN);
    assign urng_seed0 = seed;
    assign urng_seed1 = seed ^ SEED_XOR_MASK;

endmodule

// File: tb/tb_urng_seq_ctrl.sv
module tb_urng_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, u_ready;
    logic [31:0] seed_in;
    logic        busy, warm_done, urng_rst, urng_en, u_valid;
    logic [31:0] urng_seed0, urng_seed1, urng_y0, urng_y1, u0, u1, sample_cnt;

    logic        start2, stop2, u_ready2;
    logic        busy2, warm_done2, urng_rst2, urng_en2, u_valid2;
    logic [31:0] urng_seed0_2, urng_seed1_2, u0_2, u1_2;
    logic [3:0]  sample_cnt2;

    int errors = 0;
    int checks = 0;

    logic [95:0] g0, g1;   // generator state driving the DUT
    logic [95:0] m0, m1;   // golden reference stream

    urng_seq_ctrl #(.WARMUP_CYCLES(4), .LOAD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .seed_in(seed_in),
        .busy(busy), .warm_done(warm_done), .urng_rst(urng_rst),
        .urng_seed0(urng_seed0), .urng_seed1(urng_seed1), .urng_en(urng_en),
        .urng_y0(urng_y0), .urng_y1(urng_y1), .u_valid(u_valid), .u_ready(u_ready),
        .u0(u0), .u1(u1), .sample_cnt(sample_cnt)
    );

    urng_seq_ctrl #(.WARMUP_CYCLES(4), .LOAD_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .seed_in(seed_in),
        .busy(busy2), .warm_done(warm_done2), .urng_rst(urng_rst2),
        .urng_seed0(urng_seed0_2), .urng_seed1(urng_seed1_2), .urng_en(urng_en2),
        .urng_y0(urng_y0), .urng_y1(urng_y1), .u_valid(u_valid2), .u_ready(u_ready2),
        .u0(u0_2), .u1(u1_2), .sample_cnt(sample_cnt2)
    );

    function automatic logic [95:0] taus_seed(input logic [31:0] s);
        return {s, s, s};
    endfunction

    function automatic logic [95:0] taus_step(input logic [95:0] st);
        logic [31:0] a, b, c, t;
        a = st[95:64]; b = st[63:32]; c = st[31:0];
        t = ((a << 13) ^ a) >> 19; a = ((a & 32'hFFFFFFFE) << 12) ^ t;
        t = ((b << 2)  ^ b) >> 25; b = ((b & 32'hFFFFFFF8) << 4)  ^ t;
        t = ((c << 3)  ^ c) >> 11; c = ((c & 32'hFFFFFFF0) << 17) ^ t;
        return {a, b, c};
    endfunction

    function automatic logic [31:0] taus_y(input logic [95:0] st);
        return st[95:64] ^ st[63:32] ^ st[31:0];
    endfunction

    always @(posedge clk) begin
        if (urng_rst) begin
            g0 <= taus_seed(urng_seed0);
            g1 <= taus_seed(urng_seed1);
        end else if (urng_en) begin
            g0 <= taus_step(g0);
            g1 <= taus_step(g1);
        end
    end
    assign urng_y0 = taus_y(g0);
    assign urng_y1 = taus_y(g1);

    task automatic gold_init(input logic [31:0] s0, input logic [31:0] s1);
        m0 = taus_seed(s0);
        m1 = taus_seed(s1);
        repeat (4) begin
            m0 = taus_step(m0);
            m1 = taus_step(m1);
        end
    endtask

    task automatic gold_adv();
        m0 = taus_step(m0);
        m1 = taus_step(m1);
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!u_valid && n < 20) begin
            step_clk();
            n++;
        end
        checks++;
        if (u_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait: u_valid=%b after %0d cycles, required 1", name, u_valid, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; u_ready = 1'b0; seed_in = '0;
        start2 = 1'b0; stop2 = 1'b0; u_ready2 = 1'b0;
        repeat (2) step_clk();
        checks++;
        if ({busy, warm_done, urng_rst, urng_en, u_valid} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: busy/wd/rst/en/vld=%b required 00100",
                     {busy, warm_done, urng_rst, urng_en, u_valid});
        end
        checks++;
        if ({u0, u1, sample_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: u0=%h u1=%h cnt=%0d required all zero", u0, u1, sample_cnt);
        end
        checks++;
        if ({urng_seed0, urng_seed1} !== {32'hACE1F00D, 32'h32D689B4}) begin
            errors++;
            $display("FAIL reset_seed: %h %h required ACE1F00D 32D689B4", urng_seed0, urng_seed1);
        end
        reset = 1'b0;
        step_clk();
    endtask

    task automatic test_seq_timing();
        logic exp_rst, exp_en, exp_vld;
        seed_in = 32'h0; start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            exp_rst = (c <= 2);
            exp_en  = (c >= 3 && c <= 7);
            exp_vld = (c >= 8);
            checks++;
            if ({urng_rst, urng_en, u_valid} !== {exp_rst, exp_en, exp_vld}) begin
                errors++;
                $display("FAIL seq_timing c=%0d: rst/en/vld=%b required %b",
                         c, {urng_rst, urng_en, u_valid}, {exp_rst, exp_en, exp_vld});
            end
            if (c == 1) begin
                checks++;
                if ({urng_seed0, urng_seed1} !== {32'hACE1F00D, 32'h32D689B4}) begin
                    errors++;
                    $display("FAIL weak_seed0: %h %h required ACE1F00D 32D689B4",
                             urng_seed0, urng_seed1);
                end
            end
            step_clk();
        end
        gold_init(32'hACE1F00D, 32'h32D689B4);
        checks++;
        if ({busy, warm_done, u0, u1} !== {2'b11, taus_y(m0), taus_y(m1)}) begin
            errors++;
            $display("FAIL first_pair: busy/wd=%b u0=%h u1=%h required 11 %h %h",
                     {busy, warm_done}, u0, u1, taus_y(m0), taus_y(m1));
        end
    endtask

    task automatic test_stream();
        seed_in = 32'h12345678; start = 1'b1; u_ready = 1'b1;
        step_clk();
        start = 1'b0;
        checks++;
        if ({urng_seed0, urng_seed1, u_valid} !== {32'h12345678, 32'h8C032FC1, 1'b0}) begin
            errors++;
            $display("FAIL strong_seed: %h %h vld=%b required 12345678 8C032FC1 0",
                     urng_seed0, urng_seed1, u_valid);
        end
        gold_init(32'h12345678, 32'h8C032FC1);
        wait_valid("stream");
        for (int i = 0; i < 100; i++) begin
            #1;
            checks++;
            if ({u_valid, u0, u1} !== {1'b1, taus_y(m0), taus_y(m1)}) begin
                errors++;
                $display("FAIL stream[%0d]: vld=%b u0=%h u1=%h required 1 %h %h",
                         i, u_valid, u0, u1, taus_y(m0), taus_y(m1));
            end
            gold_adv();
            step_clk();
        end
        u_ready = 1'b0;
        #1;
        checks++;
        if (sample_cnt !== 32'd100) begin
            errors++;
            $display("FAIL stream_cnt: sample_cnt=%0d required 100", sample_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        for (int i = 0; i < 200; i++) begin
            u_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({u_valid, u0, u1} !== {1'b1, taus_y(m0), taus_y(m1)}) begin
                errors++;
                $display("FAIL bp_data[%0d]: vld=%b u0=%h u1=%h required 1 %h %h",
                         i, u_valid, u0, u1, taus_y(m0), taus_y(m1));
            end
            checks++;
            if (urng_en !== u_ready) begin
                errors++;
                $display("FAIL bp_en[%0d]: urng_en=%b required %b", i, urng_en, u_ready);
            end
            if (u_ready) begin
                gold_adv();
                acc++;
            end
            step_clk();
        end
        u_ready = 1'b0;
        #1;
        checks++;
        if (sample_cnt !== 32'(100 + acc)) begin
            errors++;
            $display("FAIL bp_cnt: sample_cnt=%0d required %0d", sample_cnt, 100 + acc);
        end
    endtask

    task automatic test_restart();
        u_ready = 1'b1; seed_in = 32'h0000000F; start = 1'b1;
        step_clk();
        start = 1'b0;
        checks++;
        if ({u_valid, sample_cnt, busy, warm_done, urng_rst} !== {1'b0, 32'd0, 3'b101}) begin
            errors++;
            $display("FAIL restart_ctrl: vld=%b cnt=%0d busy/wd/rst=%b required 0 0 101",
                     u_valid, sample_cnt, {busy, warm_done, urng_rst});
        end
        checks++;
        if ({urng_seed0, urng_seed1} !== {32'hACE1F00D, 32'h32D689B4}) begin
            errors++;
            $display("FAIL restart_seed: %h %h required ACE1F00D 32D689B4", urng_seed0, urng_seed1);
        end
        gold_init(32'hACE1F00D, 32'h32D689B4);
        wait_valid("restart");
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({u_valid, u0, u1} !== {1'b1, taus_y(m0), taus_y(m1)}) begin
                errors++;
                $display("FAIL restart[%0d]: u0=%h u1=%h required %h %h",
                         i, u0, u1, taus_y(m0), taus_y(m1));
            end
            gold_adv();
            step_clk();
        end
        u_ready = 1'b0;
        step_clk();
    endtask

    task automatic test_stop();
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        #1;
        checks++;
        if ({busy, warm_done, urng_rst, urng_en, u_valid} !== 5'b00100) begin
            errors++;
            $display("FAIL stop_ctrl: busy/wd/rst/en/vld=%b required 00100",
                     {busy, warm_done, urng_rst, urng_en, u_valid});
        end
        checks++;
        if ({sample_cnt, u0, u1} !== {32'd10, taus_y(m0), taus_y(m1)}) begin
            errors++;
            $display("FAIL stop_hold: cnt=%0d u0=%h u1=%h required 10 %h %h",
                     sample_cnt, u0, u1, taus_y(m0), taus_y(m1));
        end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        #1;
        checks++;
        if ({busy, urng_rst, sample_cnt, u0} !== {2'b01, 32'd10, taus_y(m0)}) begin
            errors++;
            $display("FAIL stop_idle: busy/rst=%b cnt=%0d u0=%h required 01 10 %h",
                     {busy, urng_rst}, sample_cnt, u0, taus_y(m0));
        end
        seed_in = 32'h00C0FFEE; start = 1'b1; stop = 1'b1;
        step_clk();
        start = 1'b0; stop = 1'b0;
        #1;
        checks++;
        if ({busy, warm_done, urng_rst, urng_en, sample_cnt, urng_seed0}
            !== {4'b1010, 32'd0, 32'h00C0FFEE}) begin
            errors++;
            $display("FAIL start_stop: busy/wd/rst/en=%b cnt=%0d seed0=%h required 1010 0 00C0FFEE",
                     {busy, warm_done, urng_rst, urng_en}, sample_cnt, urng_seed0);
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) step_clk();
        checks++;
        if ({busy, warm_done, urng_rst, urng_en} !== 4'b1001) begin
            errors++;
            $display("FAIL warm_state: busy/wd/rst/en=%b required 1001",
                     {busy, warm_done, urng_rst, urng_en});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, warm_done, urng_rst, urng_en, u_valid, u0, u1, sample_cnt, urng_seed0}
            !== {5'b00100, 96'd0, 32'hACE1F00D}) begin
            errors++;
            $display("FAIL async_reset: ctrl=%b u0=%h u1=%h cnt=%0d seed0=%h required 00100 0 0 0 ACE1F00D",
                     {busy, warm_done, urng_rst, urng_en, u_valid}, u0, u1, sample_cnt, urng_seed0);
        end
        step_clk();
        reset = 1'b0;
        step_clk();
    endtask

    task automatic test_saturate();
        int n = 0;
        logic [3:0] exp_cnt;
        u_ready2 = 1'b1; start2 = 1'b1;
        step_clk();
        start2 = 1'b0;
        while (!u_valid2 && n < 20) begin
            step_clk();
            n++;
        end
        checks++;
        if (u_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_wait: u_valid=%b after %0d cycles, required 1", u_valid2, n);
        end
        for (int i = 1; i <= 20; i++) begin
            step_clk();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (sample_cnt2 !== exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: sample_cnt=%0d required %0d", i, sample_cnt2, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq_timing();
        test_stream();
        test_back_to_back();
        test_restart();
        test_stop();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
